// File: rtl/multi_seg7_driver.sv
// Registered multi-digit seven-segment driver.
// Shows an unsigned value on active-low HEX displays in hex or decimal. Hex results
// appear one edge after load. Decimal results come from a sequential double-dabble
// converter that holds busy high for WIDTH cycles. Supports leading-zero blanking and
// an all-dash overflow display.
module multi_seg7_driver #(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [WIDTH-1:0]            num,
    input  logic                        hex_mode,
    input  logic                        blank_lz,
    output logic                        busy,
    output logic                        overflow,
    output logic [NUM_DIGITS-1:0][6:0]  HEX
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [0:0]       state;
    logic [WIDTH-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic             ovf_sticky;
    logic             blank_cap;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH+BCD_W-1:0] hex_wide;
    logic                   hex_ovf;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_shift;
    logic [WIDTH-1:0]       bin_shift;
    logic                   shift_out;
    logic                   conv_ovf;

    // Active-low glyph for one nibble, bit 6 = segment g.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h27;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Turns a digit vector into segment patterns. Overflow forces dashes; otherwise
    // zero digits above the highest nonzero one are blanked when requested, and
    // digit 0 always shows a glyph.
    function automatic logic [NUM_DIGITS-1:0][6:0] format_display(
        input logic [BCD_W-1:0] digits,
        input logic             ovf,
        input logic             blank
    );
        logic [NUM_DIGITS-1:0][6:0] segs;
        logic                       seen;
        segs = '0;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (ovf) begin
                segs[k] = SEG_DASH;
            end else if (blank && !seen && (k != 0) && (digits[4*k +: 4] == 4'd0)) begin
                segs[k] = SEG_BLANK;
            end else begin
                segs[k] = glyph(digits[4*k +: 4]);
                seen    = 1'b1;
            end
        end
        return segs;
    endfunction

    assign busy = (state == CONV);

    // Hex path: zero-extend num to the full digit width; any bit beyond it overflows.
    always_comb begin
        hex_wide = {{BCD_W{1'b0}}, num};
        hex_ovf  = |(hex_wide >> BCD_W);
    end

    // One double-dabble step: add-3 correction, then shift the BCD:bin pair left.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_reg[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
            end
        end
        {shift_out, bcd_shift, bin_shift} = {bcd_adj, bin_reg, 1'b0};
        conv_ovf = ovf_sticky | shift_out;
    end

    // Control FSM, converter registers and the registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            ovf_sticky <= 1'b0;
            blank_cap  <= 1'b0;
            cnt        <= '0;
            overflow   <= 1'b0;
            HEX        <= {NUM_DIGITS{SEG_BLANK}};
        end else if (state == IDLE) begin
            if (load) begin
                if (hex_mode) begin
                    HEX      <= format_display(hex_wide[BCD_W-1:0], hex_ovf, blank_lz);
                    overflow <= hex_ovf;
                end else begin
                    bin_reg    <= num;
                    bcd_reg    <= '0;
                    ovf_sticky <= 1'b0;
                    blank_cap  <= blank_lz;
                    cnt        <= CNT_W'(WIDTH);
                    state      <= CONV;
                end
            end
        end else begin
            // Intermediate values stay internal; HEX only changes on the final shift.
            bin_reg    <= bin_shift;
            bcd_reg    <= bcd_shift;
            ovf_sticky <= conv_ovf;
            cnt        <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                HEX      <= format_display(bcd_shift, conv_ovf, blank_cap);
                overflow <= conv_ovf;
                state    <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_multi_seg7_driver.sv
// Self-checking bench for multi_seg7_driver. Two instances (3 and 2 digits) share
// stimulus; expected displays come from a positional-notation model using division.
module tb_multi_seg7_driver;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             load;
    logic [WIDTH-1:0] num;
    logic             hex_mode;
    logic             blank_lz;

    logic             busy3, busy2;
    logic             ovf3, ovf2;
    logic [2:0][6:0]  hex3;
    logic [1:0][6:0]  hex2;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp3 [3];
    logic [6:0] exp2 [2];
    logic       eovf3, eovf2;

    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    multi_seg7_driver #(.WIDTH(WIDTH), .NUM_DIGITS(3)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .num(num), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(busy3), .overflow(ovf3), .HEX(hex3)
    );

    multi_seg7_driver #(.WIDTH(WIDTH), .NUM_DIGITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .load(load), .num(num), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(busy2), .overflow(ovf2), .HEX(hex2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ipow(int base, int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * base;
        return p;
    endfunction

    function automatic bit model_ovf(int value, bit hexm, int n);
        return value >= ipow(hexm ? 16 : 10, n);
    endfunction

    // Digit k of value in the chosen base, with dash/blank rules applied.
    function automatic logic [6:0] model_seg(int value, bit hexm, bit blank, int n, int k);
        int base;
        int p;
        base = hexm ? 16 : 10;
        p    = ipow(base, k);
        if (model_ovf(value, hexm, n)) return 7'h3F;
        if (blank && k > 0 && value < p) return 7'h7F;
        return GLYPH[(value / p) % base];
    endfunction

    task automatic set_model(input int value, input bit hexm, input bit blank);
        for (int k = 0; k < 3; k++) exp3[k] = model_seg(value, hexm, blank, 3, k);
        for (int k = 0; k < 2; k++) exp2[k] = model_seg(value, hexm, blank, 2, k);
        eovf3 = model_ovf(value, hexm, 3);
        eovf2 = model_ovf(value, hexm, 2);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) check_val($sformatf("%s hex3[%0d]", tag, k), 32'(hex3[k]), 32'(exp3[k]));
        for (int k = 0; k < 2; k++) check_val($sformatf("%s hex2[%0d]", tag, k), 32'(hex2[k]), 32'(exp2[k]));
        check_val({tag, " ovf3"}, 32'(ovf3), 32'(eovf3));
        check_val({tag, " ovf2"}, 32'(ovf2), 32'(eovf2));
        check_val({tag, " busy3"}, 32'(busy3), 32'd0);
        check_val({tag, " busy2"}, 32'(busy2), 32'd0);
    endtask

    task automatic run_hex(input int value, input bit blank);
        @(negedge clk);
        num      = WIDTH'(value);
        hex_mode = 1'b1;
        blank_lz = blank;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        set_model(value, 1'b1, blank);
        check_all($sformatf("hex %0d", value));
    endtask

    // Decimal load; with noise, inputs churn and loads are attempted while busy,
    // including on the edge where busy falls.
    task automatic run_dec(input int value, input bit blank, input bit noise);
        int n;
        @(negedge clk);
        num      = WIDTH'(value);
        hex_mode = 1'b0;
        blank_lz = blank;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        set_model(value, 1'b0, blank);
        check_val("busy_start", 32'(busy3), 32'd1);
        n = 0;
        while (busy3 === 1'b1 && n < 100) begin
            n++;
            if (noise) begin
                num      = WIDTH'($urandom);
                hex_mode = 1'($urandom);
                blank_lz = 1'($urandom);
                load     = (n == 3 || n == WIDTH) ? 1'b1 : 1'($urandom);
            end
            @(negedge clk);
        end
        load = 1'b0;
        check_val($sformatf("busy_len %0d", value), 32'(n), 32'(WIDTH));
        check_all($sformatf("dec %0d", value));
    endtask

    initial begin
        int v;
        bit m, b;
        reset_n  = 1'b0;
        load     = 1'b0;
        num      = '0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) exp3[k] = 7'h7F;
        for (int k = 0; k < 2; k++) exp2[k] = 7'h7F;
        eovf3 = 1'b0;
        eovf2 = 1'b0;
        check_all("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all("post_reset");

        // Known vectors with literal segment values.
        run_hex(8'h3C, 1'b1);
        check_val("t1 HEX2", 32'(hex3[2]), 32'h7F);
        check_val("t1 HEX1", 32'(hex3[1]), 32'h30);
        check_val("t1 HEX0", 32'(hex3[0]), 32'h27);
        run_dec(255, 1'b0, 1'b0);
        check_val("t2 HEX2", 32'(hex3[2]), 32'h24);
        check_val("t2 HEX1", 32'(hex3[1]), 32'h12);
        check_val("t2 HEX0", 32'(hex3[0]), 32'h12);
        run_dec(0, 1'b1, 1'b0);
        run_dec(0, 1'b0, 1'b0);
        run_dec(100, 1'b1, 1'b0);
        check_val("t4 ovf2", 32'(ovf2), 32'd1);
        run_dec(99, 1'b1, 1'b0);
        run_hex(8'hFF, 1'b0);
        run_hex(8'h10, 1'b1);
        run_dec(123, 1'b0, 1'b1);
        check_val("t5 HEX2", 32'(hex3[2]), 32'h79);
        check_val("t5 HEX1", 32'(hex3[1]), 32'h24);
        check_val("t5 HEX0", 32'(hex3[0]), 32'h30);

        // Reset in the middle of a conversion.
        @(negedge clk);
        num      = 8'd200;
        hex_mode = 1'b0;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) exp3[k] = 7'h7F;
        for (int k = 0; k < 2; k++) exp2[k] = 7'h7F;
        eovf3 = 1'b0;
        eovf2 = 1'b0;
        check_all("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (WIDTH + 2) @(negedge clk);
        check_all("after_abort");
        run_hex(8'h05, 1'b0);
        check_val("t6 HEX0", 32'(hex3[0]), 32'h12);

        // Randomized transactions with boundary-biased values.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: v = 0;
                1: v = 99 + $urandom_range(0, 1);
                2: v = 255;
                default: v = $urandom_range(0, 255);
            endcase
            m = 1'($urandom);
            b = 1'($urandom);
            if (m) run_hex(v, b);
            else   run_dec(v, b, 1'($urandom));
            // Display must hold while idle and inputs wander without load.
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                num      = WIDTH'($urandom);
                hex_mode = 1'($urandom);
                blank_lz = 1'($urandom);
            end
            @(negedge clk);
            check_all($sformatf("hold %0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
